// File: rtl/mcycle_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mcycle_ctrl -- multicycle main controller for the 8-bit processor.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> WB (data ops)
// or FETCH -> DECODE -> BRANCH (op = 11). Handles the instruction-memory
// handshake with a bounded wait, a sticky fetch-timeout fault, and a
// retired-instruction counter.
//
// Parameters:
//   TIMEOUT  fetch wait cycles tolerated before faulting (1..255)
//   CNT_W    width of the retired-instruction counter
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   op         IR[7:6]: 00 pass, 01 addi, 10 subi, 11 branch
//   funct      IR[5:4]: funct[1] = 1 makes a branch unconditional
//   zero       selected register is zero (branch condition)
//   mem_ready  instruction memory has valid data this cycle
//   mem_req    fetch request
//   irwrite    load IR (FETCH, same cycle as mem_ready)
//   pcwrite    load PC
//   pcsel      PC source: 0 = PC+1, 1 = ALU result
//   alusrc     ALU B operand: 1 = immediate, 0 = register
//   aluop      operation class for the ALU decoder
//   regwrite   register-file write enable
//   fault      sticky fetch-timeout flag
//   state      current state encoding (debug)
//   retired    count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module mcycle_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       op,
    input  logic [1:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             pcsel,
    output logic             alusrc,
    output logic [1:0]       aluop,
    output logic             regwrite,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_BRANCH = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     cur;
    logic [7:0] wait_cnt;
    logic       taken;

    // Only funct[1] selects the branch variant; funct[0] is reserved.
    logic unused_funct;
    assign unused_funct = funct[0];

    assign taken = funct[1] | zero;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= S_FETCH;
            wait_cnt <= 8'd0;
            retired  <= '0;
            fault    <= 1'b0;
        end else begin
            case (cur)
                S_FETCH: begin
                    // mem_ready wins even in the last permitted wait cycle.
                    if (mem_ready) begin
                        wait_cnt <= 8'd0;
                        cur      <= S_DECODE;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        cur      <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: cur <= (op == 2'b11) ? S_BRANCH : S_EXEC;
                S_EXEC:   cur <= S_WB;
                S_WB: begin
                    retired <= retired + 1'b1;
                    cur     <= S_FETCH;
                end
                S_BRANCH: begin
                    // A branch retires whether or not it is taken.
                    retired <= retired + 1'b1;
                    cur     <= S_FETCH;
                end
                S_FAULT: begin
                    // Sticky: only reset leaves FAULT; the flag is set on the
                    // first edge spent in FAULT.
                    fault <= 1'b1;
                    cur   <= S_FAULT;
                end
                default: begin
                    // Illegal encodings (6, 7) recover to FETCH.
                    wait_cnt <= 8'd0;
                    cur      <= S_FETCH;
                end
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned (which would infer a latch).
    always_comb begin
        mem_req  = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsel    = 1'b0;
        alusrc   = 1'b0;
        aluop    = 2'b00;
        regwrite = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                // Mealy load on the handshake; gated by reset_n so no IR/PC
                // write can slip through while reset is asserted.
                irwrite = mem_ready & reset_n;
                pcwrite = mem_ready & reset_n;
            end
            S_EXEC: begin
                alusrc = 1'b1;
                aluop  = op;
            end
            S_WB: begin
                alusrc   = 1'b1;
                aluop    = op;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrc  = 1'b1;
                aluop   = 2'b11;
                pcwrite = taken;
                pcsel   = taken;
            end
            default: ;
        endcase
    end

    assign state = cur;

endmodule
